// File: rtl/aibcr3_ddrtx_seq.sv
// DDR transmit sequencer: training preamble, word serialisation into even/odd
// pairs for the DDR output mux, and programmable idle level.
//   s_data/s_valid/s_ready : parallel word handshake
//   ddr_in0/ddr_in1        : registered even/odd bits to the DDR mux
//   busy/train_done/underflow : status
module aibcr3_ddrtx_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TRAIN_CYC = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             idle_val,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ddr_in0,
  output logic             ddr_in1,
  output logic             busy,
  output logic             train_done,
  output logic             underflow
);

  localparam int unsigned BEATS = WIDTH / 2;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]    LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_CYC - 1);

  typedef enum logic [1:0] {IDLE, TRAIN, DATA, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic               busy_word_q, busy_word_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               ddr_in0_q, ddr_in0_d;
  logic               ddr_in1_q, ddr_in1_d;
  logic               train_done_q, train_done_d;
  logic               underflow_q, underflow_d;

  logic last_beat;
  logic hs;

  assign last_beat = (beat_q == LAST_BEAT);
  assign s_ready   = (state_q == DATA) && (!busy_word_q || last_beat);
  assign hs        = s_valid && s_ready;
  assign busy      = (state_q != IDLE);

  assign ddr_in0    = ddr_in0_q;
  assign ddr_in1    = ddr_in1_q;
  assign train_done = train_done_q;
  assign underflow  = underflow_q;

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    beat_d       = beat_q;
    busy_word_d  = busy_word_q;
    shreg_d      = shreg_q;
    ddr_in0_d    = ddr_in0_q;
    ddr_in1_d    = ddr_in1_q;
    train_done_d = 1'b0;
    underflow_d  = 1'b0;

    case (state_q)
      IDLE: begin
        ddr_in0_d   = idle_val;
        ddr_in1_d   = idle_val;
        busy_word_d = 1'b0;
        beat_d      = '0;
        if (tx_en) begin
          state_d = TRAIN;
          tcnt_d  = '0;
        end
      end

      TRAIN: begin
        if (!tx_en) begin
          state_d   = IDLE;
          ddr_in0_d = idle_val;
          ddr_in1_d = idle_val;
        end else begin
          ddr_in0_d = 1'b1;
          ddr_in1_d = 1'b0;
          if (tcnt_q == TRAIN_LAST) begin
            state_d      = DATA;
            train_done_d = 1'b1;
            beat_d       = '0;
            busy_word_d  = 1'b0;
          end else begin
            tcnt_d = tcnt_q + CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (hs) begin
          // An accepted word is never dropped; losing tx_en on the same
          // edge just sends it through DRAIN.
          ddr_in0_d   = s_data[0];
          ddr_in1_d   = s_data[1];
          shreg_d     = {2'b00, s_data[WIDTH-1:2]};
          beat_d      = '0;
          busy_word_d = 1'b1;
          state_d     = tx_en ? DATA : DRAIN;
        end else if (busy_word_q && !last_beat) begin
          ddr_in0_d = shreg_q[0];
          ddr_in1_d = shreg_q[1];
          shreg_d   = {2'b00, shreg_q[WIDTH-1:2]};
          beat_d    = beat_q + BW'(1);
          if (!tx_en) state_d = DRAIN;
        end else begin
          busy_word_d = 1'b0;
          ddr_in0_d   = idle_val;
          ddr_in1_d   = idle_val;
          underflow_d = tx_en;
          if (!tx_en) state_d = IDLE;
        end
      end

      DRAIN: begin
        if (last_beat) begin
          state_d     = IDLE;
          busy_word_d = 1'b0;
          ddr_in0_d   = idle_val;
          ddr_in1_d   = idle_val;
        end else begin
          ddr_in0_d = shreg_q[0];
          ddr_in1_d = shreg_q[1];
          shreg_d   = {2'b00, shreg_q[WIDTH-1:2]};
          beat_d    = beat_q + BW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      beat_q       <= '0;
      busy_word_q  <= 1'b0;
      shreg_q      <= '0;
      ddr_in0_q    <= 1'b0;
      ddr_in1_q    <= 1'b0;
      train_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      beat_q       <= beat_d;
      busy_word_q  <= busy_word_d;
      shreg_q      <= shreg_d;
      ddr_in0_q    <= ddr_in0_d;
      ddr_in1_q    <= ddr_in1_d;
      train_done_q <= train_done_d;
      underflow_q  <= underflow_d;
    end
  end

endmodule

// File: tb/tb_aibcr3_ddrtx_seq.sv
module tb_aibcr3_ddrtx_seq;

  localparam int W  = 8;
  localparam int TC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_en;
  logic         idle_val;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic         ddr_in0;
  logic         ddr_in1;
  logic         busy;
  logic         train_done;
  logic         underflow;

  // {in0, in1, s_ready, busy, train_done, underflow}
  logic [5:0] obs;
  assign obs = {ddr_in0, ddr_in1, s_ready, busy, train_done, underflow};

  int checks = 0;
  int errors = 0;

  aibcr3_ddrtx_seq #(.WIDTH(W), .TRAIN_CYC(TC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .idle_val(idle_val),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ddr_in0(ddr_in0), .ddr_in1(ddr_in1), .busy(busy),
    .train_done(train_done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rst = 1'b1; tx_en = 1'b0; idle_val = 1'b1; s_valid = 1'b0; s_data = '0;
    step(); step();
    exp = 6'b00_0000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_state: got %b exp %b", obs, exp); end
    rst = 1'b0;
    step();
    exp = 6'b11_0000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL idle_level: got %b exp %b", obs, exp); end
  endtask

  // Starts in IDLE; ends in the first DATA cycle with no word in flight.
  task automatic run_training(input string tag);
    logic [5:0] exp;
    s_valid = 1'b0; tx_en = 1'b1;
    step();
    exp = {idle_val, idle_val, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL %s_train_entry: got %b exp %b", tag, obs, exp); end
    for (int j = 0; j < TC; j++) begin
      step();
      exp = {1'b1, 1'b0, (j == TC-1), 1'b1, (j == TC-1), 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL %s_train_cyc%0d: got %b exp %b", tag, j, obs, exp); end
    end
  endtask

  task automatic test_single_word();
    logic [7:0] tbl;
    logic [5:0] exp;
    tbl = 8'b01_00_11_01;
    idle_val = 1'b1;
    s_data = 8'b1011_0010; s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      s_valid = 1'b0; s_data = 8'($urandom);
      exp = {tbl[7-2*k -: 2], (k == 3), 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL single_beat%0d: got %b exp %b", k, obs, exp); end
    end
    step();
    exp = 6'b11_1101;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_after: got %b exp %b", obs, exp); end
  endtask

  task automatic test_stream();
    logic [15:0] tbl;
    logic [5:0]  exp;
    tbl = 16'b10_10_01_01_00_11_11_00;
    idle_val = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      step();
      s_data = (k == 4) ? 8'h3C : 8'($urandom);
      if (k == 8) s_valid = 1'b0;
      exp = {tbl[17-2*k -: 2], (k == 4 || k == 8), 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stream_pair%0d: got %b exp %b", k, obs, exp); end
    end
  endtask

  task automatic test_underflow();
    logic [5:0] exp;
    idle_val = 1'b1; s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      exp = 6'b11_1101;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL underflow_cyc%0d: got %b exp %b", k, obs, exp); end
    end
  endtask

  task automatic test_drain();
    logic [5:0] exp;
    idle_val = 1'b0;
    s_data = 8'hFF; s_valid = 1'b1;
    exp = 6'b11_0100;
    for (int k = 0; k < 4; k++) begin
      step();
      case (k)
        0: s_valid = 1'b0;
        1: begin tx_en = 1'b0; s_valid = 1'b1; s_data = 8'($urandom); end
        2: tx_en = 1'b1;
        default: ;
      endcase
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL drain_beat%0d: got %b exp %b", k, obs, exp); end
    end
    step();
    exp = 6'b00_0000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL drain_idle: got %b exp %b", obs, exp); end
    run_training("drain");
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    logic [5:0] exp;
    w = 8'($urandom);
    idle_val = 1'b1;
    s_data = w; s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      s_valid = 1'b0;
      exp = {w[2*k], w[2*k+1], 1'b0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL midrst_beat%0d: got %b exp %b", k, obs, exp); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp = 6'b00_0000;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL midrst_state: got %b exp %b", obs, exp); end
    run_training("midrst");
  endtask

  // Reference: queue of pairs still owed from the accepted word.
  task automatic test_random_stream();
    logic [1:0] q[$];
    logic [1:0] p;
    logic       rdy, e0, e1, eu;
    for (int i = 0; i < 300; i++) begin
      s_valid = ($urandom_range(0, 99) < 65);
      s_data  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) idle_val = ~idle_val;
      rdy = (q.size() == 0);
      checks++;
      if (s_ready !== rdy) begin errors++; $display("FAIL rand_ready%0d: got %b exp %b", i, s_ready, rdy); end
      if (s_valid && rdy) begin
        e0 = s_data[0]; e1 = s_data[1]; eu = 1'b0;
        for (int k = 1; k < W/2; k++) q.push_back({s_data[2*k+1], s_data[2*k]});
      end else if (q.size() != 0) begin
        p = q.pop_front();
        e0 = p[0]; e1 = p[1]; eu = 1'b0;
      end else begin
        e0 = idle_val; e1 = idle_val; eu = 1'b1;
      end
      step();
      checks++;
      if ({ddr_in0, ddr_in1, busy, train_done, underflow} !== {e0, e1, 1'b1, 1'b0, eu}) begin
        errors++;
        $display("FAIL rand_out%0d: got %b exp %b", i,
                 {ddr_in0, ddr_in1, busy, train_done, underflow}, {e0, e1, 1'b1, 1'b0, eu});
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    run_training("init");
    test_single_word();
    test_stream();
    test_underflow();
    test_drain();
    test_reset_mid_word();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
